// File: rtl/mask_row_prefetch.sv
// Mask row feeder for the exposure FSM: prefetches one pattern's row words from
// pattern memory into an output register plus one skid entry.
module mask_row_prefetch #(
   parameter int C_MASK_DES_L = 18,
   parameter int C_NUM_ROWS   = 160,
   parameter int C_ADDR_W     = 16
) (
   input  logic                    CLKMPRE,
   input  logic                    RESET_N,
   input  logic                    STREAM,
   input  logic                    FRAME_SYNC,
   input  logic [31:0]             Num_Pat,
   output logic                    PAT_RD_EN,
   output logic [C_ADDR_W-1:0]     PAT_ADDR,
   input  logic [C_MASK_DES_L-1:0] PAT_RDATA,
   output logic [C_MASK_DES_L-1:0] MASK_DATA,
   output logic                    MASK_VALID,
   output logic [31:0]             PAT_IDX,
   output logic                    ERR_UNDERRUN,
   output logic                    ERR_OVERRUN,
   output logic                    ERR_SHORT,
   output logic [1:0]              STATE_DBG
);

   localparam int RW = $clog2(C_NUM_ROWS + 1);
   localparam logic [RW-1:0] ROWS = RW'(C_NUM_ROWS);

   typedef enum logic [1:0] {
      S_FILL     = 2'd0,
      S_READY    = 2'd1,
      S_BURST    = 2'd2,
      S_WAIT_LOW = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic                    skid_valid;
   logic [C_MASK_DES_L-1:0] skid_data;
   logic                    rd_pending;
   logic [RW-1:0]           rows_iss;
   logic [RW-1:0]           rows_cons;
   logic [C_ADDR_W-1:0]     base;

   logic sync, leave, short_fall, overrun, underrun, consume, last_consume;
   logic flush, advance, restart_issue, room, rd_issue;
   logic [2:0]          fill_lvl;
   logic [31:0]         num_pat_eff, pat_nxt;
   logic [C_ADDR_W-1:0] base_nxt;

   // Handshake: every edge with STREAM=1 (outside WAIT_LOW) takes MASK_DATA when
   // MASK_VALID=1; with MASK_VALID=0 the request is an underrun and nothing moves.
   always_comb begin
      sync          = FRAME_SYNC;
      leave         = (state == S_WAIT_LOW) && !STREAM;
      short_fall    = (state == S_BURST) && !STREAM;
      overrun       = (state == S_WAIT_LOW) && STREAM && !sync;
      underrun      = (state != S_WAIT_LOW) && STREAM && !MASK_VALID && !sync;
      consume       = (state != S_WAIT_LOW) && STREAM && MASK_VALID && !sync;
      last_consume  = consume && (rows_cons == ROWS - 1'b1);
      flush         = sync || short_fall;
      advance       = (leave || short_fall) && !sync;
      restart_issue = leave && !sync;
      // A word consumed this edge frees a slot for a read issued in the same cycle.
      fill_lvl      = 3'(MASK_VALID) + 3'(skid_valid) + 3'(rd_pending);
      room          = fill_lvl < (3'd2 + 3'(consume));
      rd_issue      = restart_issue || (!flush && !leave && (rows_iss < ROWS) && room);
      num_pat_eff   = (Num_Pat == 32'd0) ? 32'd1 : Num_Pat;
      if ((PAT_IDX + 32'd1) >= num_pat_eff) begin
         pat_nxt  = 32'd0;
         base_nxt = '0;
      end else begin
         pat_nxt  = PAT_IDX + 32'd1;
         base_nxt = base + C_ADDR_W'(C_NUM_ROWS);
      end
   end

   always_ff @(posedge CLKMPRE or negedge RESET_N) begin
      if (!RESET_N) state <= S_FILL;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (sync) begin
         state_nxt = S_FILL;
      end else begin
         case (state)
            S_FILL:     if (STREAM) state_nxt = S_BURST;
                        else if (rd_pending) state_nxt = S_READY;
            S_READY:    if (last_consume) state_nxt = S_WAIT_LOW;
                        else if (STREAM) state_nxt = S_BURST;
            S_BURST:    if (!STREAM) state_nxt = S_FILL;
                        else if (last_consume) state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: if (!STREAM) state_nxt = S_FILL;
            default:    state_nxt = S_FILL;
         endcase
      end
   end

   // Leaving WAIT_LOW reads row 0 of the next pattern on the same edge so the
   // buffer is full again after three low cycles.
   always_comb begin
      STATE_DBG = state;
      PAT_RD_EN = RESET_N && rd_issue;
      PAT_ADDR  = restart_issue ? base_nxt : (base + C_ADDR_W'(rows_iss));
   end

   always_ff @(posedge CLKMPRE or negedge RESET_N) begin
      if (!RESET_N) begin
         MASK_DATA    <= '0;
         MASK_VALID   <= 1'b0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
         rd_pending   <= 1'b0;
         rows_iss     <= '0;
         rows_cons    <= '0;
         base         <= '0;
         PAT_IDX      <= 32'd0;
         ERR_UNDERRUN <= 1'b0;
         ERR_OVERRUN  <= 1'b0;
         ERR_SHORT    <= 1'b0;
      end else begin
         if (underrun)              ERR_UNDERRUN <= 1'b1;
         if (overrun)               ERR_OVERRUN  <= 1'b1;
         if (short_fall && !sync)   ERR_SHORT    <= 1'b1;
         rd_pending <= rd_issue;
         if (sync) begin
            PAT_IDX <= 32'd0;
            base    <= '0;
         end else if (advance) begin
            PAT_IDX <= pat_nxt;
            base    <= base_nxt;
         end
         if (flush || leave) begin
            rows_iss  <= restart_issue ? RW'(1) : '0;
            rows_cons <= '0;
         end else begin
            if (rd_issue) rows_iss  <= rows_iss + 1'b1;
            if (consume)  rows_cons <= rows_cons + 1'b1;
         end
         // A flush drops the in-flight read along with the buffered words.
         if (flush) begin
            MASK_DATA  <= '0;
            MASK_VALID <= 1'b0;
            skid_valid <= 1'b0;
         end else if (consume) begin
            if (skid_valid) begin
               MASK_DATA  <= skid_data;
               skid_valid <= rd_pending;
               if (rd_pending) skid_data <= PAT_RDATA;
            end else if (rd_pending) begin
               MASK_DATA <= PAT_RDATA;
            end else begin
               MASK_VALID <= 1'b0;
            end
         end else if (rd_pending) begin
            if (!MASK_VALID) begin
               MASK_DATA  <= PAT_RDATA;
               MASK_VALID <= 1'b1;
            end else begin
               skid_data  <= PAT_RDATA;
               skid_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mask_row_prefetch.sv
// Directed bench for mask_row_prefetch: pattern memory holds {p[8:0], r[8:0]}
// at address p*160+r; word stream, pattern advance and error flags are checked.
module tb_mask_row_prefetch;

   localparam int DW = 18;
   localparam int NR = 160;
   localparam int AW = 16;

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stream = 1'b0;
   logic          frame_sync = 1'b0;
   logic [31:0]   num_pat = 32'd3;
   logic          rd_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] rdata = '0;
   logic [DW-1:0] mask_data;
   logic          mask_valid;
   logic [31:0]   pat_idx;
   logic          err_underrun, err_overrun, err_short;
   logic [1:0]    state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   mask_row_prefetch #(.C_MASK_DES_L(DW), .C_NUM_ROWS(NR), .C_ADDR_W(AW)) dut (
      .CLKMPRE(clk), .RESET_N(rst_n), .STREAM(stream), .FRAME_SYNC(frame_sync),
      .Num_Pat(num_pat), .PAT_RD_EN(rd_en), .PAT_ADDR(addr), .PAT_RDATA(rdata),
      .MASK_DATA(mask_data), .MASK_VALID(mask_valid), .PAT_IDX(pat_idx),
      .ERR_UNDERRUN(err_underrun), .ERR_OVERRUN(err_overrun), .ERR_SHORT(err_short),
      .STATE_DBG(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] exp_word(input int p, input int r);
      logic [8:0] ph, rh;
      ph = p[8:0];
      rh = r[8:0];
      return {ph, rh};
   endfunction

   // Pattern memory: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en) rdata <= exp_word(int'(addr) / NR, int'(addr) % NR);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // STREAM already high: expect n consecutive rows of pattern p, one per edge.
   task automatic stream_words(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         check("word", {mask_valid, mask_data}, {1'b1, exp_word(p, i)});
         tick();
      end
   endtask

   // Burst of n_hi STREAM-high cycles on pattern p, then three low cycles.
   task automatic burst(input int p, input int n_hi);
      check("burst_idx", pat_idx, p);
      stream = 1'b1;
      stream_words(p, (n_hi < NR) ? n_hi : NR);
      for (int i = NR; i < n_hi; i++) tick();
      stream = 1'b0;
      repeat (3) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  mask_data, 0);
      check({tag, "_valid"}, mask_valid, 0);
      check({tag, "_rden"},  rd_en, 0);
      check({tag, "_addr"},  addr, 0);
      check({tag, "_idx"},   pat_idx, 0);
      check({tag, "_errs"},  {err_underrun, err_overrun, err_short}, 0);
      check({tag, "_state"}, state_dbg, ST_FILL);
   endtask

   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values while held in reset
      repeat (2) tick();
      check_reset_outputs("reset");

      // Fill sequence after release
      rst_n = 1'b1;
      #1;
      check("fill0_rden", rd_en, 1);
      check("fill0_addr", addr, 0);
      tick();
      check("fill1_valid", mask_valid, 0);
      check("fill1_rden", rd_en, 1);
      check("fill1_addr", addr, 1);
      tick();
      check("fill2_valid", mask_valid, 1);
      check("fill2_state", state_dbg, ST_READY);
      check("fill2_rden", rd_en, 0);
      tick();
      check("fill3_rden", rd_en, 0);

      // Full bursts, Num_Pat=3: pattern sequence 0,1,2,0,1
      burst(0, NR);
      check("b0_idx", pat_idx, 1);
      check("b0_state", state_dbg, ST_READY);
      check("b0_next", {mask_valid, mask_data}, {1'b1, exp_word(1, 0)});
      check("b0_errs", {err_underrun, err_overrun, err_short}, 0);
      burst(1, NR);
      check("b1_idx", pat_idx, 2);
      burst(2, NR);
      check("b2_idx_wrap", pat_idx, 0);
      burst(0, NR);
      check("b3_idx", pat_idx, 1);
      burst(1, NR);
      check("b4_idx", pat_idx, 2);
      check("b4_underrun", err_underrun, 0);

      // Overrun: 161st STREAM cycle lands in WAIT_LOW
      check("ovr_idx", pat_idx, 2);
      stream = 1'b1;
      stream_words(2, NR);
      check("ovr_state", state_dbg, ST_WAIT);
      check("ovr_hold", {mask_valid, mask_data}, {1'b0, exp_word(2, NR - 1)});
      tick();
      check("ovr_flag", err_overrun, 1);
      check("ovr_state2", state_dbg, ST_WAIT);
      check("ovr_hold2", mask_data, exp_word(2, NR - 1));
      stream = 1'b0;
      tick();
      check("ovr_adv", pat_idx, 0);
      repeat (2) tick();
      check("ovr_noshort", err_short, 0);

      // Short burst of 100 words on pattern 0
      stream = 1'b1;
      stream_words(0, 100);
      stream = 1'b0;
      tick();
      check("short_flag", err_short, 1);
      check("short_idx", pat_idx, 1);
      check("short_flush", mask_valid, 0);
      check("short_state", state_dbg, ST_FILL);
      repeat (2) tick();
      check("short_refill", {mask_valid, mask_data}, {1'b1, exp_word(1, 0)});
      burst(1, NR);

      // FRAME_SYNC at row 50 of pattern 2
      check("fs_idx_pre", pat_idx, 2);
      stream = 1'b1;
      stream_words(2, 50);
      check("fs_row50", mask_data, exp_word(2, 50));
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      stream = 1'b0;
      check("fs_idx", pat_idx, 0);
      check("fs_flush", {mask_valid, mask_data}, 0);
      check("fs_state", state_dbg, ST_FILL);
      tick();
      check("fs_valid1", mask_valid, 0);
      tick();
      check("fs_valid2", {mask_valid, mask_data}, {1'b1, exp_word(0, 0)});
      tick();
      burst(0, NR);
      check("fs_after_idx", pat_idx, 1);
      check("fs_underrun", err_underrun, 0);

      // Asynchronous reset in the middle of a burst
      stream = 1'b1;
      stream_words(1, 20);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");
      stream = 1'b0;
      repeat (2) tick();

      // STREAM raised one cycle after release: underrun, then the burst continues
      rst_n = 1'b1;
      tick();
      check("udr_valid0", mask_valid, 0);
      stream = 1'b1;
      tick();
      check("udr_flag", err_underrun, 1);
      check("udr_state", state_dbg, ST_BURST);
      stream_words(0, NR);
      stream = 1'b0;
      tick();
      check("udr_idx", pat_idx, 1);
      check("udr_other", {err_overrun, err_short}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
